axi_lite_master: RTL
====================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have parameter AXIL_DATA_WIDTH, default 32, giving the data bus width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter AXIL_ADDR_WIDTH, default 4, giving the address bus width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have command ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1; 1 = write, 0 = read), cmd_addr (in, AXIL_ADDR_WIDTH), cmd_wdata (in, AXIL_DATA_WIDTH) and cmd_wstrb (in, AXIL_DATA_WIDTH/8).
REQ-006 The block SHALL have response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_write (out, 1), rsp_rdata (out, AXIL_DATA_WIDTH) and rsp_resp (out, 2).
REQ-007 The block SHALL have AXI4-Lite write-channel master ports awvalid/awready, awaddr (AXIL_ADDR_WIDTH), wvalid/wready, wdata (AXIL_DATA_WIDTH), wstrb (AXIL_DATA_WIDTH/8), and bvalid/bready, bresp (2).
REQ-008 The block SHALL have AXI4-Lite read-channel master ports arvalid/arready, araddr (AXIL_ADDR_WIDTH), and rvalid/rready, rdata (AXIL_DATA_WIDTH), rresp (2).
REQ-009 The block SHALL have port busy, output, 1 bit, which is high whenever the FSM is not in IDLE.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-011 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-012 On acceptance, addr, wdata, wstrb and the write flag SHALL be registered, and later changes on cmd_* SHALL have no effect on the transaction.
REQ-013 An accepted write SHALL move the FSM to WR_REQ, with awvalid=1 and wvalid=1 from the next cycle.
REQ-014 In WR_REQ, awvalid SHALL deassert in the cycle after its own handshake and wvalid in the cycle after its own handshake; the two are independent, in either order or simultaneously.
REQ-015 Once both the AW and W handshakes have completed, the FSM SHALL enter WR_RESP with bready=1 from the next cycle.
REQ-016 An accepted read SHALL move the FSM to RD_REQ, with arvalid=1 from the next cycle until the AR handshake, then to RD_RESP with rready=1 from the next cycle.
REQ-017 On the B or R handshake, bresp, or rdata and rresp, SHALL be captured, bready/rready SHALL drop, and the FSM SHALL enter DONE.
REQ-018 In DONE, rsp_valid SHALL be 1 with stable rsp_*; rsp_write SHALL equal the command's write flag, and rsp_rdata SHALL be 0 for writes.
REQ-019 On rsp_valid and rsp_ready both 1, the FSM SHALL return to IDLE, so at most one transaction is outstanding.
REQ-020 Once asserted, each of awvalid, wvalid and arvalid SHALL stay high with stable payload until its handshake, and SHALL never depend combinationally on the matching ready.
REQ-021 With a zero-wait slave and rsp_ready held at 1, a write SHALL take 4 cycles from command acceptance to the rsp handshake, and a read SHALL take 4 cycles.
REQ-022 An early bvalid or rvalid arriving before bready or rready is asserted SHALL simply wait, with nothing lost.
REQ-023 All resp codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL pass through unmodified, and the block SHALL not retry.

Reset
REQ-024 While reset=0, the FSM SHALL be in IDLE, and cmd_ready SHALL be 0.
REQ-025 While reset=0, awvalid, wvalid, arvalid, bready, rready, rsp_valid and busy SHALL be 0, and all address, data, strobe and resp outputs SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately, and no rsp SHALL be produced for it.
REQ-027 cmd_ready SHALL rise in the first clock after reset deasserts.

Verification
REQ-028 The bench SHALL cover: write addr=0x4, wdata=0xDEADBEEF, wstrb=0xF to a zero-wait slave -> awaddr=0x4 and wdata=0xDEADBEEF seen at the handshake, rsp_write=1, rsp_resp=0, 4-cycle latency.
REQ-029 The bench SHALL cover: read addr=0x8, slave returns 0x12345678/OKAY after 3 wait cycles on arready and 2 on rvalid -> rsp_rdata=0x12345678, rsp_resp=0, arvalid stable throughout.
REQ-030 The bench SHALL cover: write with wready 5 cycles before awready, and the reverse order -> each valid drops independently, and bready rises only after both handshakes.
REQ-031 The bench SHALL cover: bresp=2'b10 with rsp_ready held 0 for 6 cycles -> rsp_valid and rsp_resp=2'b10 held stable, and cmd_ready stays 0 until the rsp handshake.
REQ-032 The bench SHALL cover: reset asserted in RD_RESP -> all outputs go to 0 asynchronously, then a fresh read after deassert completes normally.
REQ-033 The bench SHALL cover: back-to-back commands with cmd_valid held high -> the second command is accepted in the cycle after the first rsp handshake.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: runs one read or write per command and
// returns the slave response on a valid/ready response port.
module axi_lite_master #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
  output logic                         wvalid,
  input  logic                         wready,
  output logic [AXIL_DATA_WIDTH-1:0]   wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  input  logic                         bvalid,
  output logic                         bready,
  input  logic [1:0]                   bresp,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                   rresp,
  output logic                         busy
);

  localparam int SW = AXIL_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state, state_n;

  logic                       live;
  logic                       write_q;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]              wstrb_q;

  logic aw_n, w_n, ar_n, b_n, r_n;
  logic accept, b_hs, r_hs;

  // live holds cmd_ready low until the first edge out of reset
  assign cmd_ready = live && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign b_hs      = bvalid && bready;
  assign r_hs      = rvalid && rready;

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_write = write_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    aw_n    = awvalid;
    w_n     = wvalid;
    ar_n    = arvalid;
    b_n     = bready;
    r_n     = rready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_write) begin
            state_n = WR_REQ;
            aw_n    = 1'b1;
            w_n     = 1'b1;
          end else begin
            state_n = RD_REQ;
            ar_n    = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once both are done
        if (awready) aw_n = 1'b0;
        if (wready)  w_n  = 1'b0;
        if (!aw_n && !w_n) begin
          state_n = WR_RESP;
          b_n     = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_n = DONE;
          b_n     = 1'b0;
        end
      end
      RD_REQ: begin
        if (arvalid && arready) begin
          state_n = RD_RESP;
          ar_n    = 1'b0;
          r_n     = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_n = DONE;
          r_n     = 1'b0;
        end
      end
      DONE: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live      <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      live    <= 1'b1;
      awvalid <= aw_n;
      wvalid  <= w_n;
      arvalid <= ar_n;
      bready  <= b_n;
      rready  <= r_n;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= bresp;
      end
      if (r_hs) begin
        rsp_rdata <= rdata;
        rsp_resp  <= rresp;
      end
    end
  end

endmodule
